// File: rtl/apb_slave_regbank.sv
// APB completer holding NUM_REGS 32-bit read/write registers with WAIT_CYCLES wait states.
// Define APB_SLV_PSLVERR_EN to flag out-of-range or misaligned accesses on Pslverr.
module apb_slave_regbank #(
    parameter int          NUM_REGS    = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic        Psel,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    output logic [31:0] Prdata,
    output logic        Pready,
    output logic        Pslverr
);

    localparam int          IDX_W  = $clog2(NUM_REGS);
    localparam logic [31:0] SPAN   = 32'(4 * NUM_REGS);
    localparam logic [3:0]  WAIT_N = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t             state_reg, state_next;
    logic [3:0]         wcnt_reg, wcnt_next;
    logic [31:0]        offset;
    logic               hit;
    logic [IDX_W-1:0]   idx;
    logic               access_phase;
    logic               complete;
    logic [31:0]        regs_reg [NUM_REGS];

    // Addresses below BASE_ADDR wrap to huge offsets, so one compare covers both bounds.
    assign offset = Paddr - BASE_ADDR;
    assign hit    = (offset < SPAN) && (offset[1:0] == 2'b00);
    assign idx    = offset[IDX_W+1:2];

    // state_reg records the phase sampled at the last edge; a cycle with Psel&Penable
    // following a sampled setup (or a wait) is an access cycle, so a zero-wait transfer
    // completes in its first access cycle.
    assign access_phase = Psel & Penable & (state_reg != IDLE);
    assign Pready       = access_phase & (wcnt_reg == WAIT_N);
    assign complete     = Pready;

    assign Prdata = (access_phase & ~Pwrite & hit) ? regs_reg[idx] : 32'h0;

`ifdef APB_SLV_PSLVERR_EN
    assign Pslverr = Pready & ~hit;
`else
    assign Pslverr = 1'b0;
`endif

    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            state_reg <= IDLE;
            wcnt_reg  <= 4'd0;
        end else begin
            state_reg <= state_next;
            wcnt_reg  <= wcnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        wcnt_next  = wcnt_reg;
        case (state_reg)
            IDLE: begin
                // An access phase with no preceding setup is ignored.
                if (Psel && !Penable) begin
                    state_next = SETUP;
                    wcnt_next  = 4'd0;
                end
            end
            SETUP, ACCESS: begin
                if (!Psel) begin
                    state_next = IDLE;
                end else if (!Penable) begin
                    state_next = SETUP;
                    wcnt_next  = 4'd0;
                end else if (Pready) begin
                    state_next = IDLE;
                end else begin
                    state_next = ACCESS;
                    wcnt_next  = wcnt_reg + 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                wcnt_next  = 4'd0;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            always_ff @(posedge Hclk) begin
                if (!Hresetn) begin
                    regs_reg[gi] <= 32'h0;
                end else if (complete && Pwrite && hit && (idx == IDX_W'(gi))) begin
                    regs_reg[gi] <= Pwdata;
                end
            end
        end
    endgenerate

endmodule
